adder_seq: RTL and testbench
============================

Name: adder_seq

Overview:
- Multi-digit sequencer around the existing 2-bit `Adder` stage: sits directly upstream (drives its io_cin/io_lhs/io_rhs) and downstream (consumes its io_out/io_cout).
- Accepts WIDTH-bit operands over a valid/ready handshake and feeds them to the adder 2 bits per cycle, LSB digit first.
- Chains the carry through a register, assembles the WIDTH-bit sum and presents it on a valid/ready output.
- Used wherever wide additions are needed at low area cost.

Parameters:
WIDTH, 8, operand/result width; must be an even number ≥ 2 (elaboration error otherwise)
DIGITS, WIDTH/2 (derived, not overridable), number of 2-bit digit steps

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
io_in_valid  input  1  operand transfer valid
io_in_ready  output  1  block can accept operands
io_in_lhs  input  WIDTH  left operand
io_in_rhs  input  WIDTH  right operand
io_in_cin  input  1  carry-in
io_add_lhs  output  2  digit to adder io_lhs
io_add_rhs  output  2  digit to adder io_rhs
io_add_cin  output  1  carry to adder io_cin
io_add_sum  input  2  adder io_out (combinational return)
io_add_cout  input  1  adder io_cout
io_out_valid  output  1  result valid
io_out_ready  input  1  consumer accepts result
io_out_sum  output  WIDTH  result sum
io_out_cout  output  1  result carry-out

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, io_in_ready=1, io_out_valid=0.
  - io_out_sum=0, io_out_cout=0, digit index=0, carry register=0.
  - io_add_lhs/io_add_rhs/io_add_cin=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - io_in_ready=1.
  - On io_in_valid&io_in_ready: latch lhs/rhs into shift registers, carry reg←io_in_cin, index←0, clear sum reg, go to RUN.
- RUN:
  - io_in_ready=0.
  - io_add_lhs/io_add_rhs = digit[index] of latched operands; io_add_cin = carry reg.
  - Adder is combinational, so its result is captured at the end of the same cycle: sum bits [2i+1:2i]←io_add_sum, carry reg←io_add_cout, index++.
  - When index==DIGITS-1 is captured, go to DONE.
  - RUN lasts exactly DIGITS cycles.
- DONE:
  - io_out_valid=1; io_out_sum=assembled sum; io_out_cout=carry reg.
  - Outputs hold stable while io_out_ready=0.
  - On io_out_valid&io_out_ready, go to IDLE.
- io_add_* are driven to 0 outside RUN.
- Latency: accept edge → io_out_valid asserted DIGITS cycles later.
- Throughput: at most 1 op per DIGITS+2 cycles. io_in_ready is never high in DONE; a new operand is accepted only in IDLE, the cycle after the output handshake.
- Arithmetic: {io_out_cout,io_out_sum} = lhs+rhs+cin, exact to WIDTH+1 bits.
- Boundary conditions:
  - All-ones + cin=1 ripples the carry through every digit.
  - WIDTH=2 gives a single RUN cycle.
  - io_in_* changing during RUN/DONE is ignored; the latched copies are used.
- Reset mid-RUN or mid-DONE: returns to IDLE next edge, drops io_out_valid, discards the in-flight op; no partial result is emitted.
- io_in_valid asserted together with reset is not accepted.

Optional Feature:
- Macro ADDER_SEQ_OVERFLOW_EN.
- When defined:
  - Adds output port io_out_ovf (1 bit): two's-complement signed overflow of lhs+rhs+cin.
  - Computed during the last RUN step as carry_into_msb ^ io_add_cout, where carry_into_msb = io_add_sum[1] ^ lhs[WIDTH-1] ^ rhs[WIDTH-1].
  - Registered, valid with io_out_valid; reset value 0.
- When undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- WIDTH=8: lhs=0x5A, rhs=0x3C, cin=0 → after 4 RUN cycles io_out_valid=1, sum=0x96, cout=0. Bench checks io_add_lhs sequence 2,2,1,1 (0x5A digits LSB first).
- WIDTH=8: lhs=0xFF, rhs=0x00, cin=1 → sum=0x00, cout=1. Carry ripples all 4 digits, so io_add_cin=1 on every RUN cycle.
- Backpressure: result ready with io_out_ready=0 for 3 cycles → io_out_valid, sum and cout held constant. io_in_valid=1 during that time is not accepted (io_in_ready=0). Accepted only in IDLE after the handshake.
- Reset asserted on the 2nd RUN cycle of lhs=0x12, rhs=0x34 → next cycle IDLE, io_in_ready=1, io_out_valid=0. A following op 0x01+0x01 yields 0x02, cout=0 with no stale digits.
- Back-to-back ops: 0xAA+0x55+0 then 0x80+0x80+0 → 0xFF/cout0, then 0x00/cout1. Each has 4-cycle latency; io_in_ready pattern matches IDLE/RUN/DONE exactly.
- With ADDER_SEQ_OVERFLOW_EN: 0x7F+0x01+0 → sum=0x80, io_out_ovf=1; 0xFF+0x01+0 → sum=0x00, cout=1, io_out_ovf=0.

Source files
------------

// File: rtl/adder_seq.sv
// Multi-digit sequential adder: feeds WIDTH-bit operands through an external 2-bit adder
// stage one digit per cycle, LSB first. Optional signed-overflow output under ADDER_SEQ_OVERFLOW_EN.
module adder_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_lhs,
  input  logic [WIDTH-1:0] io_in_rhs,
  input  logic             io_in_cin,
  output logic [1:0]       io_add_lhs,
  output logic [1:0]       io_add_rhs,
  output logic             io_add_cin,
  input  logic [1:0]       io_add_sum,
  input  logic             io_add_cout,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_sum,
  output logic             io_out_cout
`ifdef ADDER_SEQ_OVERFLOW_EN
  ,
  output logic             io_out_ovf
`endif
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
      $error("adder_seq: WIDTH must be an even number >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lhs_q, lhs_d;
  logic [WIDTH-1:0]   rhs_q, rhs_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [WIDTH+1:0]   sum_cat;
  logic               last_step;

  // Operands shift right so the current digit is always in bits [1:0]; the sum fills
  // from the top so digit 0 ends up at the bottom after DIGITS steps.
  assign sum_cat   = {io_add_sum, sum_q};
  assign last_step = (state_q == StRun) && (idx_q == LastIdx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      lhs_q   <= '0;
      rhs_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lhs_d        = lhs_q;
    rhs_d        = rhs_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    io_out_sum   = '0;
    io_out_cout  = 1'b0;
    io_add_lhs   = 2'b00;
    io_add_rhs   = 2'b00;
    io_add_cin   = 1'b0;

    unique case (state_q)
      StIdle: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          lhs_d   = io_in_lhs;
          rhs_d   = io_in_rhs;
          carry_d = io_in_cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        io_add_lhs = lhs_q[1:0];
        io_add_rhs = rhs_q[1:0];
        io_add_cin = carry_q;
        sum_d      = sum_cat[WIDTH+1:2];
        carry_d    = io_add_cout;
        lhs_d      = lhs_q >> 2;
        rhs_d      = rhs_q >> 2;
        idx_d      = idx_q + 1'b1;
        if (last_step) begin
          state_d = StDone;
        end
      end
      StDone: begin
        io_out_valid = 1'b1;
        io_out_sum   = sum_q;
        io_out_cout  = carry_q;
        if (io_out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ADDER_SEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // On the last step lhs_q[1]/rhs_q[1] hold the original operand MSBs.
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == StIdle) && io_in_valid) begin
      ovf_d = 1'b0;
    end else if (last_step) begin
      ovf_d = io_add_sum[1] ^ lhs_q[1] ^ rhs_q[1] ^ io_add_cout;
    end
  end

  assign io_out_ovf = (state_q == StDone) && ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: models the 2-bit adder stage and checks every op
// against plain-arithmetic expectations (ADDER_SEQ_OVERFLOW_EN adds overflow checks).
module tb_adder_seq;

  localparam int W      = 8;
  localparam int DIGITS = W / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_lhs;
  logic [W-1:0] in_rhs;
  logic         in_cin;
  logic [1:0]   add_lhs;
  logic [1:0]   add_rhs;
  logic         add_cin;
  logic [1:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef ADDER_SEQ_OVERFLOW_EN
  logic         out_ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural 2-bit adder stage
  assign {add_cout, add_sum} = {1'b0, add_lhs} + {1'b0, add_rhs} + {2'b00, add_cin};

  adder_seq #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_in_valid (in_valid),
    .io_in_ready (in_ready),
    .io_in_lhs   (in_lhs),
    .io_in_rhs   (in_rhs),
    .io_in_cin   (in_cin),
    .io_add_lhs  (add_lhs),
    .io_add_rhs  (add_rhs),
    .io_add_cin  (add_cin),
    .io_add_sum  (add_sum),
    .io_add_cout (add_cout),
    .io_out_valid(out_valid),
    .io_out_ready(out_ready),
    .io_out_sum  (out_sum),
    .io_out_cout (out_cout)
`ifdef ADDER_SEQ_OVERFLOW_EN
    ,
    .io_out_ovf  (out_ovf)
`endif
  );

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Carry entering digit i = bit 2i of the sum of the lower 2i bits plus cin
  function automatic logic ref_carry(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input int i);
    longint unsigned m, s;
    m = (64'd1 << (2 * i)) - 64'd1;
    s = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
    return s[2*i];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  // Drives one op starting from IDLE at a negedge, holds the result for `hold` extra
  // cycles, and returns at the negedge after the output handshake.
  task automatic run_op(input logic [W-1:0] lhs, input logic [W-1:0] rhs, input logic cin,
                        input int hold, input string tag, output logic [W-1:0] seen_lhs,
                        output logic [DIGITS-1:0] seen_cin);
    logic [W:0] exp;
    logic [1:0] dl, dr;
    logic       dc;
    exp      = ref_sum(lhs, rhs, cin);
    seen_lhs = '0;
    seen_cin = '0;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s idle_ready: got %b want 1", tag, in_ready);
    end
    in_valid  = 1'b1;
    in_lhs    = lhs;
    in_rhs    = rhs;
    in_cin    = cin;
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DIGITS; i++) begin
      dl = 2'(lhs >> (2 * i));
      dr = 2'(rhs >> (2 * i));
      dc = ref_carry(lhs, rhs, cin, i);
      seen_lhs[2*i+:2] = add_lhs;
      seen_cin[i]      = add_cin;
      tests++;
      if ({in_ready, out_valid, add_lhs, add_rhs, add_cin} !== {2'b00, dl, dr, dc}) begin
        fails++;
        $display("FAIL %s run_digit%0d: got rdy=%b vld=%b lhs=%0d rhs=%0d cin=%b want 0 0 %0d %0d %b",
                 tag, i, in_ready, out_valid, add_lhs, add_rhs, add_cin, dl, dr, dc);
      end
      // Operand inputs are ignored while busy
      in_valid = 1'($urandom);
      in_lhs   = W'($urandom);
      in_rhs   = W'($urandom);
      in_cin   = 1'($urandom);
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      tests++;
      if ({out_valid, in_ready, out_cout, out_sum, add_lhs, add_rhs, add_cin}
          !== {2'b10, exp, 5'b0}) begin
        fails++;
        $display("FAIL %s done_hold%0d: got vld=%b rdy=%b cout=%b sum=%h add=%0d/%0d/%b want 1 0 %b %h 0/0/0",
                 tag, h, out_valid, in_ready, out_cout, out_sum, add_lhs, add_rhs, add_cin,
                 exp[W], exp[W-1:0]);
      end
`ifdef ADDER_SEQ_OVERFLOW_EN
      tests++;
      if (out_ovf !== ref_ovf(lhs, rhs, cin)) begin
        fails++;
        $display("FAIL %s ovf: got %b want %b", tag, out_ovf, ref_ovf(lhs, rhs, cin));
      end
`endif
      in_valid  = 1'b1;
      in_lhs    = W'($urandom);
      out_ready = (h == hold);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL %s back_to_idle: got rdy=%b vld=%b want 1 0", tag, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_lhs    = 8'hFF;
    in_rhs    = 8'hFF;
    in_cin    = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_sum, out_cout, add_lhs, add_rhs, add_cin}
        !== {2'b10, {W{1'b0}}, 6'b0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b add=%0d/%0d/%b want 1 0 00 0 0/0/0",
               in_ready, out_valid, out_sum, out_cout, add_lhs, add_rhs, add_cin);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, add_lhs} !== 4'b1000) begin
      fails++;
      $display("FAIL post_reset_idle: got rdy=%b vld=%b add_lhs=%0d want 1 0 0",
               in_ready, out_valid, add_lhs);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0]      sl;
    logic [DIGITS-1:0] sc;
    run_op(8'h5A, 8'h3C, 1'b0, 0, "basic", sl, sc);
    tests++;
    if (sl !== 8'h5A) begin
      fails++;
      $display("FAIL basic_digit_seq: got %h want 5a (digits 2,2,1,1)", sl);
    end
  endtask

  task automatic test_ripple();
    logic [W-1:0]      sl;
    logic [DIGITS-1:0] sc;
    run_op(8'hFF, 8'h00, 1'b1, 0, "ripple", sl, sc);
    tests++;
    if (sc !== {DIGITS{1'b1}}) begin
      fails++;
      $display("FAIL ripple_cin_all: got %b want %b", sc, {DIGITS{1'b1}});
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]      sl;
    logic [DIGITS-1:0] sc;
    run_op(8'hC3, 8'h7E, 1'b1, 3, "backpressure", sl, sc);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0]      sl;
    logic [DIGITS-1:0] sc;
    in_valid = 1'b1;
    in_lhs   = 8'h12;
    in_rhs   = 8'h34;
    in_cin   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, add_lhs, add_rhs} !== 6'b100000) begin
      fails++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b add=%0d/%0d want 1 0 0/0",
               in_ready, out_valid, add_lhs, add_rhs);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, add_lhs} !== 4'b1000) begin
      fails++;
      $display("FAIL valid_with_reset_ignored: got rdy=%b vld=%b add_lhs=%0d want 1 0 0",
               in_ready, out_valid, add_lhs);
    end
    run_op(8'h01, 8'h01, 1'b0, 0, "after_reset", sl, sc);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]      sl;
    logic [DIGITS-1:0] sc;
    run_op(8'hAA, 8'h55, 1'b0, 0, "b2b_first", sl, sc);
    run_op(8'h80, 8'h80, 1'b0, 0, "b2b_second", sl, sc);
  endtask

  task automatic test_random();
    logic [W-1:0]      sl;
    logic [DIGITS-1:0] sc;
    for (int n = 0; n < 24; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random",
             sl, sc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

`ifdef ADDER_SEQ_OVERFLOW_EN
  task automatic test_overflow();
    logic [W-1:0]      sl;
    logic [DIGITS-1:0] sc;
    run_op(8'h7F, 8'h01, 1'b0, 0, "ovf_pos", sl, sc);
    run_op(8'hFF, 8'h01, 1'b0, 0, "ovf_none", sl, sc);
    run_op(8'h80, 8'hFF, 1'b0, 0, "ovf_neg", sl, sc);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef ADDER_SEQ_OVERFLOW_EN
    test_overflow();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
